// File: rtl/oam_dma_arbiter.sv
// Sprite-DMA controller and CPU/DMA bus arbiter: a CPU write to DMA_REG_ADDR copies one 256-byte page to OAM_DATA_ADDR.
// Optional feature macro OAM_DMA_PARITY_ALIGN_EN adds the parity counter and ALIGN state so every DMA read lands on parity 0.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_rw,
    input  logic [7:0]  bus_data_in,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
`ifdef OAM_DMA_PARITY_ALIGN_EN
    localparam logic [2:0] ST_ALIGN = 3'd2;
`endif
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] latch_q, latch_d;
    logic       trigger_s;

    assign trigger_s = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_PARITY_ALIGN_EN
    logic parity_q;

    // Free-running cycle parity used to place every READ on an even cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end
`endif

    // Next-state logic for the DMA sequencer.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    page_d  = cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
                if (parity_q == 1'b0) begin
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_READ;
                end
`else
                state_d = ST_READ;
`endif
            end
`ifdef OAM_DMA_PARITY_ALIGN_EN
            ST_ALIGN: state_d = ST_READ;
`endif
            ST_READ: begin
                latch_d = bus_data_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset abandons any DMA in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            latch_q <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
        end
    end

    // Bus mux: CPU passthrough when idle, DMA addressing otherwise; the index never carries into the page.
    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_rw       = cpu_rw;
        dma_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus_addr     = cpu_addr;
                bus_data_out = cpu_data_out;
                bus_rw       = cpu_rw;
            end
            ST_HALT: begin
                bus_rw       = 1'b1;
                bus_data_out = 8'h00;
            end
`ifdef OAM_DMA_PARITY_ALIGN_EN
            ST_ALIGN: begin
                bus_rw       = 1'b1;
                bus_data_out = 8'h00;
            end
`endif
            ST_READ: begin
                bus_addr     = {page_q, idx_q};
                bus_rw       = 1'b1;
                bus_data_out = 8'h00;
            end
            ST_WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_rw       = 1'b0;
                bus_data_out = latch_q;
                dma_done     = (idx_q == LAST_IDX);
            end
            default: begin
                bus_addr     = cpu_addr;
                bus_data_out = cpu_data_out;
                bus_rw       = cpu_rw;
            end
        endcase
    end

    assign cpu_halt   = (state_q != ST_IDLE);
    assign dma_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: expected bus writes/DMA reads are queued at stimulus time and popped by a monitor.
module tb_oam_dma_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_rw;
    logic [7:0]  bus_data_in;
    logic        dma_active;
    logic        dma_done;

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_q [$];
    logic [15:0] rd_q [$];
    int          checks = 0;
    int          errors = 0;
    int          halt_tot = 0;
    int          done_tot = 0;
    int          done_at = 0;
    logic        mon_en = 1'b0;
    logic        tb_par = 1'b0;

    oam_dma_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_rw      (cpu_rw),
        .cpu_halt    (cpu_halt),
        .bus_addr    (bus_addr),
        .bus_data_out(bus_data_out),
        .bus_rw      (bus_rw),
        .bus_data_in (bus_data_in),
        .dma_active  (dma_active),
        .dma_done    (dma_done)
    );

    assign bus_data_in = mem[bus_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle parity: cleared by reset, toggles every cycle.
    always @(posedge clock) tb_par <= reset ? 1'b0 : ~tb_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every bus write and every DMA page read.
    always @(negedge clock) begin
        logic [23:0] ew;
        logic [15:0] er;
        if (mon_en) begin
            if (cpu_halt === 1'b1) halt_tot = halt_tot + 1;
            if (dma_done === 1'b1) begin
                done_tot = done_tot + 1;
                done_at  = halt_tot;
            end
            if (bus_rw !== 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus_addr, bus_data_out);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", {16'h0000, bus_addr}, {16'h0000, ew[23:8]});
                    check("wr_data", {24'h000000, bus_data_out}, {24'h000000, ew[7:0]});
                end
            end else if (dma_active === 1'b1 && bus_addr !== cpu_addr) begin
                if (rd_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL rd_unexpected: got addr %0h expected no read", bus_addr);
                end else begin
                    er = rd_q.pop_front();
                    check("rd_addr", {16'h0000, bus_addr}, {16'h0000, er});
                end
            end
        end
    end

    task automatic do_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        cpu_addr     = 16'h8000;
        cpu_rw       = 1'b1;
        cpu_data_out = 8'h00;
    endtask

    // Queue expectations for a DMA of `page` covering indices 0..last, then issue the trigger write.
    task automatic trigger(input logic [7:0] page, input logic par, input int last);
        logic [7:0] ii;
        for (int n = 0; n < 4 && tb_par != par; n++) begin
            set_idle();
            do_cycle();
        end
        wr_q.push_back({16'h4014, page});
        for (int i = 0; i <= last; i++) begin
            ii = i[7:0];
            rd_q.push_back({page, ii});
            wr_q.push_back({16'h2004, mem[{page, ii}]});
        end
        cpu_addr     = 16'h4014;
        cpu_rw       = 1'b0;
        cpu_data_out = page;
        do_cycle();
        set_idle();
    endtask

    task automatic run_dma(input string name, input logic [7:0] page, input logic par, input int exp_len);
        int h0;
        int d0;
        h0 = halt_tot;
        d0 = done_tot;
        trigger(page, par, 255);
        for (int n = 0; n < 600; n++) begin
            if (cpu_halt !== 1'b1) break;
            do_cycle();
        end
        check({name, "_halt_len"}, halt_tot - h0, exp_len);
        check({name, "_done_cnt"}, done_tot - d0, 1);
        check({name, "_done_last"}, done_at, halt_tot);
        check({name, "_wr_left"}, wr_q.size(), 0);
        check({name, "_rd_left"}, rd_q.size(), 0);
    endtask

    task automatic no_trigger(input string name, input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_addr     = a;
        cpu_rw       = rw;
        cpu_data_out = d;
        if (rw == 1'b0) wr_q.push_back({a, d});
        do_cycle();
        set_idle();
        #1;
        check({name, "_halt"}, {31'h0, cpu_halt}, 32'h0);
        check({name, "_active"}, {31'h0, dma_active}, 32'h0);
    endtask

    initial begin
        int len_p1;
`ifdef OAM_DMA_PARITY_ALIGN_EN
        len_p1 = 514;
`else
        len_p1 = 513;
`endif
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = i[7:0];
            mem[16'hFF00 + i] = ~i[7:0];
            mem[16'h0300 + i] = i[7:0] ^ 8'hA5;
        end
        mem[16'h0000] = 8'hEE;

        reset = 1'b1;
        set_idle();
        repeat (3) do_cycle();
        reset        = 1'b0;
        cpu_addr     = 16'h1234;
        cpu_rw       = 1'b1;
        cpu_data_out = 8'h5C;
        mon_en       = 1'b1;
        #1;
        check("rst_bus_addr", {16'h0, bus_addr}, 32'h1234);
        check("rst_bus_rw", {31'h0, bus_rw}, 32'h1);
        check("rst_bus_data", {24'h0, bus_data_out}, 32'h5C);
        check("rst_halt", {31'h0, cpu_halt}, 32'h0);
        check("rst_active", {31'h0, dma_active}, 32'h0);
        check("rst_done", {31'h0, dma_done}, 32'h0);
        do_cycle();

        run_dma("p02_par0", 8'h02, 1'b0, 513);
        run_dma("p02_par1", 8'h02, 1'b1, len_p1);
        run_dma("pFF_par0", 8'hFF, 1'b0, 513);

        no_trigger("rd4014", 16'h4014, 1'b1, 8'h02);
        no_trigger("wr4015", 16'h4015, 1'b0, 8'h11);
        no_trigger("wr4013", 16'h4013, 1'b0, 8'h22);

        // Abort at the WRITE of idx 100, which is the 203rd cycle after the trigger cycle.
        trigger(8'h02, 1'b0, 100);
        repeat (202) do_cycle();
        check("abort_active_before", {31'h0, dma_active}, 32'h1);
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        #1;
        check("abort_halt", {31'h0, cpu_halt}, 32'h0);
        check("abort_active", {31'h0, dma_active}, 32'h0);
        check("abort_done", {31'h0, dma_done}, 32'h0);
        check("abort_bus_addr", {16'h0, bus_addr}, 32'h8000);
        check("abort_bus_rw", {31'h0, bus_rw}, 32'h1);
        check("abort_wr_left", wr_q.size(), 0);
        check("abort_rd_left", rd_q.size(), 0);
        do_cycle();

        run_dma("p03_restart", 8'h03, 1'b0, 513);

        repeat (4) do_cycle();
        check("final_wr_left", wr_q.size(), 0);
        check("final_rd_left", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
